// File: rtl/game_phase_sequencer.sv
// Game-flow controller: LOGO -> GET_READY -> PLAY -> TIMES_UP -> LEADERBOARD.
// Drives the screen-select and powerup flags for the VGA controller and keeps
// the gameplay countdown as two BCD digits. Runs on the VGA pixel clock.
// Optional build macro ATTRACT_TIMEOUT_EN: the leaderboard times out back to
// the logo screen after ATTRACT_SECONDS without a start press.
module game_phase_sequencer #(
  parameter int CLK_HZ          = 25000000,
  parameter int GAME_SECONDS    = 60,
  parameter int READY_SECONDS   = 3,
  parameter int TIMESUP_SECONDS = 3,
  parameter int BONUS_SECONDS   = 10,
  parameter int ATTRACT_SECONDS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       two_player_mode,
  input  logic       turner_caught,
  output logic       logo,
  output logic       get_ready,
  output logic       times_up,
  output logic       leaderboard,
  output logic       playing,
  output logic [3:0] time_tens,
  output logic [3:0] time_ones,
  output logic       sec_tick,
  output logic       snitch_powerup,
  output logic       broom_powerup,
  output logic       lightning_powerup,
  output logic       time_turner_powerup
);

  localparam logic [2:0] ST_LOGO    = 3'd0;
  localparam logic [2:0] ST_READY   = 3'd1;
  localparam logic [2:0] ST_PLAY    = 3'd2;
  localparam logic [2:0] ST_TIMESUP = 3'd3;
  localparam logic [2:0] ST_BOARD   = 3'd4;

  localparam int DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_HZ - 1);

  // The phase counter must hold the longest of the per-screen durations.
  localparam int PH_MAX0 = (READY_SECONDS > TIMESUP_SECONDS) ? READY_SECONDS : TIMESUP_SECONDS;
  localparam int PH_MAX1 = (PH_MAX0 > ATTRACT_SECONDS) ? PH_MAX0 : ATTRACT_SECONDS;
  localparam int PH_W    = (PH_MAX1 > 1) ? $clog2(PH_MAX1 + 1) : 1;
  localparam logic [PH_W-1:0] PH_ONE = PH_W'(1);

  localparam logic [7:0] GAME_BCD = {4'(GAME_SECONDS / 10), 4'(GAME_SECONDS % 10)};
  localparam logic [3:0] BONUS_T  = 4'(BONUS_SECONDS / 10);
  localparam logic [3:0] BONUS_O  = 4'(BONUS_SECONDS % 10);

  // Two-digit BCD decrement with borrow from tens; 00 stays 00.
  function automatic logic [7:0] bcd_dec(input logic [7:0] t);
    if (t == 8'h00)          return 8'h00;
    else if (t[3:0] == 4'd0) return {t[7:4] - 4'd1, 4'd9};
    else                     return {t[7:4], t[3:0] - 4'd1};
  endfunction

  // Two-digit BCD add of the bonus, saturating at 99.
  function automatic logic [7:0] bcd_add_bonus(input logic [7:0] t);
    logic [4:0] o;
    logic [4:0] tn;
    logic       c;
    o  = {1'b0, t[3:0]} + {1'b0, BONUS_O};
    c  = (o > 5'd9);
    if (c) o = o - 5'd10;
    tn = {1'b0, t[7:4]} + {1'b0, BONUS_T} + {4'd0, c};
    if (tn > 5'd9) return 8'h99;
    else           return {tn[3:0], o[3:0]};
  endfunction

  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [7:0]       time_q, time_d, time_step;
  logic             bonus_used_q, bonus_used_d;
  logic             start_q;
  logic             start_rise, counting, tick, bonus_take, in_play_d;
  logic             logo_q, get_ready_q, times_up_q, leaderboard_q, playing_q;
  logic             sec_tick_q, snitch_q, broom_q, lightning_q, turner_q;

  // Edge detector for the start button.
  // NOTE: start_q keeps sampling during reset so a button held across reset
  // is not seen as a fresh press afterwards; it therefore has no reset value.
  always_ff @(posedge clk) begin
    start_q <= start;
  end

  assign start_rise = start & ~start_q;
  assign bonus_take = (state_q == ST_PLAY) && turner_caught && !bonus_used_q;

`ifdef ATTRACT_TIMEOUT_EN
  assign counting = (state_q == ST_READY) || (state_q == ST_PLAY) ||
                    (state_q == ST_TIMESUP) || (state_q == ST_BOARD);
`else
  assign counting = (state_q == ST_READY) || (state_q == ST_PLAY) ||
                    (state_q == ST_TIMESUP);
`endif
  assign tick = counting && (div_q == DIV_MAX);

  // Next-state logic for phase, countdown, bonus and divider.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d      = state_q;
    phase_d      = phase_q;
    time_d       = time_q;
    time_step    = time_q;
    bonus_used_d = bonus_used_q;
    case (state_q)
      ST_LOGO: begin
        if (start_rise) begin
          state_d = ST_READY;
          phase_d = PH_W'(READY_SECONDS);
        end
      end
      ST_READY: begin
        if (tick) begin
          if (phase_q <= PH_ONE) begin
            state_d      = ST_PLAY;
            time_d       = GAME_BCD;
            bonus_used_d = 1'b0;
          end else begin
            phase_d = phase_q - PH_ONE;
          end
        end
      end
      ST_PLAY: begin
        if (tick) time_step = bcd_dec(time_q);
        if (bonus_take) begin
          time_step    = bcd_add_bonus(time_step);
          bonus_used_d = 1'b1;
        end
        time_d = time_step;
        // A bonus on the final tick lifts the time above 00 and keeps play going.
        if (tick && time_step == 8'h00) begin
          state_d = ST_TIMESUP;
          phase_d = PH_W'(TIMESUP_SECONDS);
        end
      end
      ST_TIMESUP: begin
        if (tick) begin
          if (phase_q <= PH_ONE) begin
            state_d = ST_BOARD;
`ifdef ATTRACT_TIMEOUT_EN
            phase_d = PH_W'(ATTRACT_SECONDS);
`endif
          end else begin
            phase_d = phase_q - PH_ONE;
          end
        end
      end
      ST_BOARD: begin
        if (start_rise) begin
          state_d = ST_READY;
          phase_d = PH_W'(READY_SECONDS);
        end
`ifdef ATTRACT_TIMEOUT_EN
        else if (tick) begin
          if (phase_q <= PH_ONE) state_d = ST_LOGO;
          else                   phase_d = phase_q - PH_ONE;
        end
`endif
      end
      default: state_d = ST_LOGO;
    endcase

    // Each phase starts with a full second; idle screens hold the divider at 0.
    if (state_d != state_q || !counting || tick) div_d = '0;
    else                                         div_d = div_q + DIV_W'(1);
  end

  assign in_play_d = (state_d == ST_PLAY);

  // State and registered outputs, the flags taken from next-state values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_LOGO;
      div_q         <= '0;
      phase_q       <= '0;
      time_q        <= GAME_BCD;
      bonus_used_q  <= 1'b0;
      logo_q        <= 1'b1;
      get_ready_q   <= 1'b0;
      times_up_q    <= 1'b0;
      leaderboard_q <= 1'b0;
      playing_q     <= 1'b0;
      sec_tick_q    <= 1'b0;
      snitch_q      <= 1'b0;
      broom_q       <= 1'b0;
      lightning_q   <= 1'b0;
      turner_q      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values regardless of statement order.
      state_q       <= state_d;
      div_q         <= div_d;
      phase_q       <= phase_d;
      time_q        <= time_d;
      bonus_used_q  <= bonus_used_d;
      logo_q        <= (state_d == ST_LOGO);
      get_ready_q   <= (state_d == ST_READY);
      times_up_q    <= (state_d == ST_TIMESUP);
      leaderboard_q <= (state_d == ST_BOARD);
      playing_q     <= in_play_d;
      sec_tick_q    <= tick;
      snitch_q      <= in_play_d && !two_player_mode && time_d >= 8'h41 && time_d <= 8'h45;
      broom_q       <= in_play_d && time_d >= 8'h31 && time_d <= 8'h35;
      lightning_q   <= in_play_d && time_d >= 8'h21 && time_d <= 8'h25;
      turner_q      <= in_play_d && !bonus_used_d && time_d >= 8'h11 && time_d <= 8'h15;
    end
  end

  assign logo                = logo_q;
  assign get_ready           = get_ready_q;
  assign times_up            = times_up_q;
  assign leaderboard         = leaderboard_q;
  assign playing             = playing_q;
  assign time_tens           = time_q[7:4];
  assign time_ones           = time_q[3:0];
  assign sec_tick            = sec_tick_q;
  assign snitch_powerup      = snitch_q;
  assign broom_powerup       = broom_q;
  assign lightning_powerup   = lightning_q;
  assign time_turner_powerup = turner_q;

endmodule

// File: tb/tb_game_phase_sequencer.sv
// Directed bench for game_phase_sequencer: three instances (12 s, 50 s and
// 99 s games, 10 clocks per second) share clock and inputs; each scenario
// resets everything and checks only the instance it is about.
module tb_game_phase_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, tp, turner;

  logic a_logo, a_gr, a_tu, a_lb, a_play, a_tick, a_sn, a_br, a_li, a_tt;
  logic [3:0] a_tens, a_ones;
  logic b_logo, b_gr, b_tu, b_lb, b_play, b_tick, b_sn, b_br, b_li, b_tt;
  logic [3:0] b_tens, b_ones;
  logic c_logo, c_gr, c_tu, c_lb, c_play, c_tick, c_sn, c_br, c_li, c_tt;
  logic [3:0] c_tens, c_ones;

  int total = 0;
  int bad   = 0;

  game_phase_sequencer #(.CLK_HZ(10), .GAME_SECONDS(12), .ATTRACT_SECONDS(2)) dut_a (
    .clk(clk), .reset(reset), .start(start), .two_player_mode(tp), .turner_caught(turner),
    .logo(a_logo), .get_ready(a_gr), .times_up(a_tu), .leaderboard(a_lb), .playing(a_play),
    .time_tens(a_tens), .time_ones(a_ones), .sec_tick(a_tick), .snitch_powerup(a_sn),
    .broom_powerup(a_br), .lightning_powerup(a_li), .time_turner_powerup(a_tt));

  game_phase_sequencer #(.CLK_HZ(10), .GAME_SECONDS(50)) dut_b (
    .clk(clk), .reset(reset), .start(start), .two_player_mode(tp), .turner_caught(turner),
    .logo(b_logo), .get_ready(b_gr), .times_up(b_tu), .leaderboard(b_lb), .playing(b_play),
    .time_tens(b_tens), .time_ones(b_ones), .sec_tick(b_tick), .snitch_powerup(b_sn),
    .broom_powerup(b_br), .lightning_powerup(b_li), .time_turner_powerup(b_tt));

  game_phase_sequencer #(.CLK_HZ(10), .GAME_SECONDS(99)) dut_c (
    .clk(clk), .reset(reset), .start(start), .two_player_mode(tp), .turner_caught(turner),
    .logo(c_logo), .get_ready(c_gr), .times_up(c_tu), .leaderboard(c_lb), .playing(c_play),
    .time_tens(c_tens), .time_ones(c_ones), .sec_tick(c_tick), .snitch_powerup(c_sn),
    .broom_powerup(c_br), .lightning_powerup(c_li), .time_turner_powerup(c_tt));

  function automatic logic [7:0] time_of(input int w);
    case (w)
      0:       return {a_tens, a_ones};
      1:       return {b_tens, b_ones};
      default: return {c_tens, c_ones};
    endcase
  endfunction

  function automatic logic tick_of(input int w);
    case (w)
      0:       return a_tick;
      1:       return b_tick;
      default: return c_tick;
    endcase
  endfunction

  function automatic logic playing_of(input int w);
    case (w)
      0:       return a_play;
      1:       return b_play;
      default: return c_play;
    endcase
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Advance one clock; outputs are stable 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input int w, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 25 && !seen; i++) begin
      step();
      if (tick_of(w)) seen = 1'b1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL %s: sec_tick got none in 25 cycles, want one", tag); end
  endtask

  task automatic wait_playing(input int w, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      step();
      if (playing_of(w)) seen = 1'b1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL %s: playing got 0 after 50 cycles, want 1", tag); end
  endtask

  // Run until the tick that brings instance w to the target time.
  task automatic play_until(input int w, input logic [7:0] target, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 1200 && !seen; i++) begin
      step();
      if (tick_of(w) && time_of(w) == target) seen = 1'b1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL %s: time never reached %h (now %h)", tag, target, time_of(w)); end
  endtask

  task automatic new_game(input logic tp_val);
    reset = 1'b1; start = 1'b0; turner = 1'b0; tp = tp_val;
    step(); step();
    reset = 1'b0;
    start = 1'b1;
    step();
  endtask

  task automatic test_reset();
    int ticks = 0;
    reset = 1'b1; start = 1'b0; tp = 1'b0; turner = 1'b0;
    step(); step();
    total++;
    if ({a_logo, a_gr, a_tu, a_lb, a_play} !== 5'b10000) begin
      bad++; $display("FAIL reset_flags: got %b want 10000", {a_logo, a_gr, a_tu, a_lb, a_play});
    end
    total++;
    if ({a_tick, a_sn, a_br, a_li, a_tt} !== 5'b00000) begin
      bad++; $display("FAIL reset_pulses: got %b want 00000", {a_tick, a_sn, a_br, a_li, a_tt});
    end
    total++;
    if ({a_tens, a_ones} !== 8'h12) begin bad++; $display("FAIL reset_time_a: got %h want 12", {a_tens, a_ones}); end
    total++;
    if ({c_tens, c_ones} !== 8'h99) begin bad++; $display("FAIL reset_time_c: got %h want 99", {c_tens, c_ones}); end
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (a_tick) ticks++;
    end
    total++;
    if (a_logo !== 1'b1 || ticks != 0) begin
      bad++; $display("FAIL logo_idle: got logo=%b ticks=%0d want logo=1 ticks=0", a_logo, ticks);
    end
  endtask

  task automatic test_get_ready();
    int  ticks = 0;
    bit  stayed = 1'b1;
    start = 1'b1;
    step();
    total++;
    if (a_gr !== 1'b1 || a_logo !== 1'b0) begin
      bad++; $display("FAIL enter_ready: got gr=%b logo=%b want gr=1 logo=0", a_gr, a_logo);
    end
    for (int i = 1; i < 30; i++) begin
      step();
      if (a_tick) ticks++;
      if (a_gr !== 1'b1) stayed = 1'b0;
    end
    total++;
    if (!stayed || ticks != 2) begin
      bad++; $display("FAIL ready_hold: got stayed=%0d ticks=%0d want stayed=1 ticks=2", stayed, ticks);
    end
    step();
    total++;
    if ({a_play, a_gr, a_tick, a_tens, a_ones} !== {3'b101, 8'h12}) begin
      bad++; $display("FAIL enter_play: got play=%b gr=%b tick=%b time=%h want 1 0 1 12",
                      a_play, a_gr, a_tick, {a_tens, a_ones});
    end
  endtask

  task automatic test_play_through();
    for (int k = 11; k >= 0; k--) begin
      wait_tick(0, "play_tick");
      total++;
      if ({a_tens, a_ones} !== to_bcd(k)) begin
        bad++; $display("FAIL play_time: got %h want %h", {a_tens, a_ones}, to_bcd(k));
      end
      total++;
      if ({a_play, a_tu} !== ((k > 0) ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL play_state at T=%0d: got play=%b tu=%b", k, a_play, a_tu);
      end
    end
    for (int j = 1; j <= 3; j++) begin
      wait_tick(0, "timesup_tick");
      total++;
      if ({a_tu, a_lb} !== ((j < 3) ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL timesup_len tick %0d: got tu=%b lb=%b", j, a_tu, a_lb);
      end
    end
    total++;
    if ({a_tens, a_ones} !== 8'h00) begin bad++; $display("FAIL time_hold: got %h want 00", {a_tens, a_ones}); end
  endtask

`ifdef ATTRACT_TIMEOUT_EN
  task automatic test_attract();
    wait_tick(0, "attract_tick1");
    total++;
    if (a_lb !== 1'b1) begin bad++; $display("FAIL attract_early: got lb=%b want 1", a_lb); end
    wait_tick(0, "attract_tick2");
    total++;
    if ({a_logo, a_lb} !== 2'b10) begin
      bad++; $display("FAIL attract_logo: got logo=%b lb=%b want 1 0", a_logo, a_lb);
    end
    start = 1'b0;
  endtask
`else
  task automatic test_board_hold();
    bit stayed = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (a_lb !== 1'b1 || a_tick !== 1'b0) stayed = 1'b0;
    end
    total++;
    if (!stayed) begin bad++; $display("FAIL board_hold: got left leaderboard or ticked, want steady"); end
    start = 1'b0;
  endtask
`endif

  task automatic test_start_on_expiry();
    bit seen = 1'b0;
    bit stayed = 1'b1;
    new_game(1'b0);
    for (int i = 0; i < 400 && !seen; i++) begin
      step();
      if (a_lb) seen = 1'b1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL reach_board: got lb=0 after 400 cycles, want 1"); end
    start = 1'b0;
    for (int i = 1; i < 20; i++) begin
      step();
      if (a_lb !== 1'b1) stayed = 1'b0;
    end
    total++;
    if (!stayed) begin bad++; $display("FAIL board_before_expiry: got lb dropped, want 1"); end
    start = 1'b1;
    step();
    total++;
    if ({a_gr, a_lb, a_logo} !== 3'b100) begin
      bad++; $display("FAIL start_on_expiry: got gr=%b lb=%b logo=%b want 1 0 0", a_gr, a_lb, a_logo);
    end
    start = 1'b0;
  endtask

  task automatic test_windows(input logic tp_val);
    logic [3:0] exp_v;
    new_game(tp_val);
    wait_playing(1, "win_play");
    total++;
    if ({b_tens, b_ones, b_sn, b_br, b_li, b_tt} !== {8'h50, 4'b0000}) begin
      bad++; $display("FAIL win_entry: got time=%h flags=%b want 50 0000",
                      {b_tens, b_ones}, {b_sn, b_br, b_li, b_tt});
    end
    for (int k = 49; k >= 0; k--) begin
      wait_tick(1, "win_tick");
      exp_v = {(k >= 41 && k <= 45 && !tp_val), (k >= 31 && k <= 35),
               (k >= 21 && k <= 25), (k >= 11 && k <= 15)};
      total++;
      if ({b_tens, b_ones, b_sn, b_br, b_li, b_tt} !== {to_bcd(k), exp_v}) begin
        bad++; $display("FAIL window tp=%b T=%0d: got time=%h flags=%b want %h %b", tp_val, k,
                        {b_tens, b_ones}, {b_sn, b_br, b_li, b_tt}, to_bcd(k), exp_v);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_bonus();
    new_game(1'b0);
    wait_playing(1, "bonus_play");
    play_until(1, 8'h14, "bonus_to_14");
    total++;
    if (b_tt !== 1'b1) begin bad++; $display("FAIL turner_window: got %b want 1", b_tt); end
    turner = 1'b1; step(); turner = 1'b0;
    total++;
    if ({b_tens, b_ones, b_tt} !== {8'h24, 1'b0}) begin
      bad++; $display("FAIL bonus_add: got time=%h tt=%b want 24 0", {b_tens, b_ones}, b_tt);
    end
    play_until(1, 8'h20, "bonus_to_20");
    turner = 1'b1; step(); turner = 1'b0;
    total++;
    if ({b_tens, b_ones} !== 8'h20) begin bad++; $display("FAIL bonus_once: got %h want 20", {b_tens, b_ones}); end
    play_until(1, 8'h13, "bonus_to_13");
    total++;
    if (b_tt !== 1'b0) begin bad++; $display("FAIL turner_after_use: got %b want 0", b_tt); end
    start = 1'b0;
  endtask

  task automatic test_bonus_last_tick();
    new_game(1'b0);
    wait_playing(1, "last_play");
    play_until(1, 8'h01, "last_to_01");
    for (int i = 0; i < 9; i++) step();
    turner = 1'b1; step(); turner = 1'b0;
    total++;
    if ({b_tick, b_play, b_tu, b_tens, b_ones} !== {3'b110, 8'h10}) begin
      bad++; $display("FAIL bonus_on_tick: got tick=%b play=%b tu=%b time=%h want 1 1 0 10",
                      b_tick, b_play, b_tu, {b_tens, b_ones});
    end
    wait_tick(1, "last_next");
    total++;
    if ({b_tens, b_ones} !== 8'h09) begin bad++; $display("FAIL after_bonus_tick: got %h want 09", {b_tens, b_ones}); end
    start = 1'b0;
  endtask

  task automatic test_saturate_and_reset();
    bit stayed = 1'b1;
    new_game(1'b0);
    wait_playing(2, "sat_play");
    play_until(2, 8'h95, "sat_to_95");
    turner = 1'b1; step(); turner = 1'b0;
    total++;
    if ({c_tens, c_ones} !== 8'h99) begin bad++; $display("FAIL bonus_saturate: got %h want 99", {c_tens, c_ones}); end
    step(); step(); step();
    reset = 1'b1; turner = 1'b1;
    step();
    reset = 1'b0; turner = 1'b0;
    total++;
    if ({c_logo, c_play, c_tick, c_tens, c_ones} !== {3'b100, 8'h99}) begin
      bad++; $display("FAIL reset_mid_play: got logo=%b play=%b tick=%b time=%h want 1 0 0 99",
                      c_logo, c_play, c_tick, {c_tens, c_ones});
    end
    for (int i = 0; i < 40; i++) begin
      step();
      if (c_logo !== 1'b1 || c_gr !== 1'b0) stayed = 1'b0;
    end
    total++;
    if (!stayed) begin bad++; $display("FAIL held_start: got game restarted, want logo held"); end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_get_ready();
    test_play_through();
`ifdef ATTRACT_TIMEOUT_EN
    test_attract();
`else
    test_board_hold();
`endif
    test_start_on_expiry();
    test_windows(1'b0);
    test_windows(1'b1);
    test_bonus();
    test_bonus_last_tick();
    test_saturate_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog");
  end

endmodule
